// File: rtl/switch_input_port_pkg.sv
// Shared constants and types for the switch input port, so the CPU top and the bench agree.
package switch_input_port_pkg;

    localparam int unsigned WIDTH        = 4;
    localparam int unsigned DB_LIMIT_HW  = 50000;
    localparam int unsigned DB_LIMIT_SIM = 4;
    localparam int unsigned DB_CW        = 16;
    localparam int unsigned CNT_W        = 8;

    // Per-group status handed from a debounce group to the top.
    typedef struct packed {
        logic done;     // first commit since reset has happened
        logic commit;   // stab is being (re)loaded from cand on this edge
        logic differs;  // cand differs from the currently committed value
    } grp_status_t;

    // A commit counts as a change only once the group has a committed value to compare with.
    function automatic logic qualifies(input grp_status_t st);
        return st.done & st.commit & st.differs;
    endfunction

endpackage

// File: rtl/switch_input_port_if.sv
// CPU-facing bundle of the switch input port: raw switches in, debounced values and status out.
interface switch_input_port_if
    import switch_input_port_pkg::*;
();

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             clear_changed;
    logic [WIDTH-1:0] input_port1;
    logic [WIDTH-1:0] input_port2;
    logic             input_valid;
    logic             changed;
    logic             change_pulse;
    logic [CNT_W-1:0] change_count;

    modport master (
        output op1, op2, clear_changed,
        input  input_port1, input_port2, input_valid, changed, change_pulse, change_count
    );

    modport slave (
        input  op1, op2, clear_changed,
        output input_port1, input_port2, input_valid, changed, change_pulse, change_count
    );

endinterface

// File: rtl/switch_input_port_debounce_group.sv
// One switch group: 2-FF synchroniser followed by a whole-vector debouncer.
module switch_input_port_debounce_group #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DB_LIMIT = 50000,
    parameter int unsigned DB_CW    = 16
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [WIDTH-1:0]                  i_raw,
    output logic [WIDTH-1:0]                  o_stab,
    output switch_input_port_pkg::grp_status_t o_status
);

    localparam logic [DB_CW-1:0] LP_CNT_MAX = DB_CW'(DB_LIMIT - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_stab;
    logic [DB_CW-1:0] r_cnt;
    logic             r_done;
    logic             w_match;
    logic             w_commit;

    // Two-stage synchroniser for the asynchronous switch inputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Window bookkeeping: a stable candidate that has filled the window commits.
    always_comb begin
        w_match  = (r_sync2 == r_cand);
        w_commit = w_match && (r_cnt == LP_CNT_MAX);
    end

    // Candidate/counter/stable registers; any change in the synchronised value restarts the window.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cand <= '0;
            r_cnt  <= '0;
            r_stab <= '0;
            r_done <= 1'b0;
        end else if (!w_match) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (!w_commit) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            // Counter saturates here; re-committing the same value is harmless.
            r_stab <= r_cand;
            r_done <= 1'b1;
        end
    end

    assign o_stab           = r_stab;
    assign o_status.done    = r_done;
    assign o_status.commit  = w_commit;
    assign o_status.differs = (r_cand != r_stab);

endmodule

// File: rtl/switch_input_port.sv
// Switch input port: two debounced switch groups plus sticky change flag, strobe and counter.
module switch_input_port
    import switch_input_port_pkg::*;
#(
    parameter int unsigned DB_LIMIT = DB_LIMIT_HW,
    parameter int unsigned DB_CW    = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    switch_input_port_if.slave   io_port
);

    logic [WIDTH-1:0] w_stab1;
    logic [WIDTH-1:0] w_stab2;
    grp_status_t      w_st1;
    grp_status_t      w_st2;
    logic             w_q1;
    logic             w_q2;
    logic             w_valid_next;
    logic             w_changed_next;
    logic [CNT_W-1:0] w_count_next;

    logic             r_valid;
    logic             r_changed;
    logic             r_pulse;
    logic [CNT_W-1:0] r_count;

    switch_input_port_debounce_group #(
        .WIDTH    (WIDTH),
        .DB_LIMIT (DB_LIMIT),
        .DB_CW    (DB_CW)
    ) u_group1 (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_raw    (io_port.op1),
        .o_stab   (w_stab1),
        .o_status (w_st1)
    );

    switch_input_port_debounce_group #(
        .WIDTH    (WIDTH),
        .DB_LIMIT (DB_LIMIT),
        .DB_CW    (DB_CW)
    ) u_group2 (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_raw    (io_port.op2),
        .o_stab   (w_stab2),
        .o_status (w_st2)
    );

    // Merge per-group commits into the status next-state; a new change beats a clear.
    always_comb begin
        w_q1           = qualifies(w_st1);
        w_q2           = qualifies(w_st2);
        w_valid_next   = (w_st1.done | w_st1.commit) & (w_st2.done | w_st2.commit);
        w_changed_next = r_changed;
        if (w_q1 || w_q2) begin
            w_changed_next = 1'b1;
        end else if (io_port.clear_changed) begin
            w_changed_next = 1'b0;
        end
        w_count_next = r_count + CNT_W'(w_q1) + CNT_W'(w_q2);
    end

    // Status registers, so every output comes straight from a flop.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_pulse   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_valid   <= w_valid_next;
            r_changed <= w_changed_next;
            r_pulse   <= w_q1 | w_q2;
            r_count   <= w_count_next;
        end
    end

    assign io_port.input_port1  = w_stab1;
    assign io_port.input_port2  = w_stab2;
    assign io_port.input_valid  = r_valid;
    assign io_port.changed      = r_changed;
    assign io_port.change_pulse = r_pulse;
    assign io_port.change_count = r_count;

endmodule

// File: tb/tb_switch_input_port.sv
// Randomised + directed bench for switch_input_port with a sliding-window reference model.
module tb_switch_input_port;
    import switch_input_port_pkg::*;

    localparam int unsigned LIM = DB_LIMIT_SIM;

    typedef logic [WIDTH-1:0] val_t;
    typedef struct packed {
        val_t             p1;
        val_t             p2;
        logic             valid;
        logic             changed;
        logic             pulse;
        logic [CNT_W-1:0] count;
    } snap_t;

    logic clk = 1'b0;
    logic rst;

    switch_input_port_if u_if ();

    switch_input_port #(
        .DB_LIMIT (LIM),
        .DB_CW    (DB_CW)
    ) u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_port (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    snap_t exp_q[$];

    // Reference model state
    val_t             m_raw [2][$];   // raw samples taken at recent edges
    val_t             m_s   [2][$];   // synchronised values seen over the last LIM+1 edges
    val_t             m_stab[2];
    bit               m_done[2];
    bit               m_changed;
    logic [CNT_W-1:0] m_count;

    function automatic snap_t dut_snap();
        snap_t s;
        s.p1      = u_if.input_port1;
        s.p2      = u_if.input_port2;
        s.valid   = u_if.input_valid;
        s.changed = u_if.changed;
        s.pulse   = u_if.change_pulse;
        s.count   = u_if.change_count;
        return s;
    endfunction

    // Model: a group commits value v once the synchronised value (raw delayed two edges)
    // has been v at each of the last LIM+1 edges. After reset the candidate is 0 with a
    // fresh window, so that reset point itself counts as one sample of 0.
    always @(posedge clk) begin
        snap_t e;
        bit    qual [2];
        val_t  raw_now [2];
        raw_now[0] = u_if.op1;
        raw_now[1] = u_if.op2;
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                m_raw[g].delete();
                m_raw[g].push_back('0);
                m_raw[g].push_back('0);
                m_s[g].delete();
                m_s[g].push_back('0);
                m_stab[g] = '0;
                m_done[g] = 1'b0;
            end
            m_changed = 1'b0;
            m_count   = '0;
            e         = '0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                val_t s;
                bit   stable;
                qual[g] = 1'b0;
                m_raw[g].push_back(raw_now[g]);
                s = m_raw[g].pop_front();
                m_s[g].push_back(s);
                if (m_s[g].size() > int'(LIM) + 1) void'(m_s[g].pop_front());
                stable = (m_s[g].size() == int'(LIM) + 1);
                foreach (m_s[g][k]) if (m_s[g][k] != s) stable = 1'b0;
                if (stable) begin
                    qual[g]   = m_done[g] && (s != m_stab[g]);
                    m_stab[g] = s;
                    m_done[g] = 1'b1;
                end
            end
            if (qual[0] || qual[1]) m_changed = 1'b1;
            else if (u_if.clear_changed) m_changed = 1'b0;
            m_count   = m_count + CNT_W'(qual[0]) + CNT_W'(qual[1]);
            e.p1      = m_stab[0];
            e.p2      = m_stab[1];
            e.valid   = m_done[0] && m_done[1];
            e.changed = m_changed;
            e.pulse   = qual[0] || qual[1];
            e.count   = m_count;
        end
        exp_q.push_back(e);
    end

    // Monitor: every cycle the DUT presents a full status word; compare against the scoreboard.
    always @(negedge clk) begin
        snap_t e;
        snap_t a;
        a = dut_snap();
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at %0t: got p1=%0h p2=%0h cnt=%0d, required an entry",
                     $time, a.p1, a.p2, a.count);
        end else begin
            e = exp_q.pop_front();
            if (rst) e = '0;
            if (a !== e) begin
                n_fail++;
                $display({"FAIL status at %0t: got p1=%0h p2=%0h v=%0b ch=%0b pl=%0b cnt=%0d, ",
                          "required p1=%0h p2=%0h v=%0b ch=%0b pl=%0b cnt=%0d"}, $time,
                         a.p1, a.p2, a.valid, a.changed, a.pulse, a.count,
                         e.p1, e.p2, e.valid, e.changed, e.pulse, e.count);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
        end
    endtask

    task automatic set_ops(input val_t a, input val_t b);
        @(negedge clk);
        #1;
        u_if.op1 = a;
        u_if.op2 = b;
    endtask

    task automatic hold(input int n);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int   h1;
        int   h2;
        val_t v1;
        val_t v2;
        rst                = 1'b1;
        u_if.op1           = 4'h5;
        u_if.op2           = 4'h0;
        u_if.clear_changed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_port1", 32'(u_if.input_port1), 32'h0);
        check("reset_valid", 32'(u_if.input_valid), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // 1: first commit lands on edge 7 and is not a change
        edges(6);
        check("t1_port1_early", 32'(u_if.input_port1), 32'h0);
        check("t1_valid_early", 32'(u_if.input_valid), 32'h0);
        edges(1);
        check("t1_port1", 32'(u_if.input_port1), 32'h5);
        check("t1_valid", 32'(u_if.input_valid), 32'h1);
        check("t1_changed", 32'(u_if.changed), 32'h0);
        check("t1_count", 32'(u_if.change_count), 32'h0);

        // 2: op2 0->9 commits exactly 7 edges later with one pulse
        set_ops(4'h5, 4'h9);
        edges(6);
        check("t2_port2_early", 32'(u_if.input_port2), 32'h0);
        edges(1);
        check("t2_port2", 32'(u_if.input_port2), 32'h9);
        check("t2_pulse", 32'(u_if.change_pulse), 32'h1);
        check("t2_changed", 32'(u_if.changed), 32'h1);
        check("t2_count", 32'(u_if.change_count), 32'h1);
        edges(1);
        check("t2_pulse_once", 32'(u_if.change_pulse), 32'h0);

        // 3: bouncing 5/A every 2 cycles, then A held
        for (int i = 0; i < 4; i++) begin
            set_ops((i % 2 == 0) ? 4'hA : 4'h5, 4'h9);
            hold(2);
            check("t3_no_update", 32'(u_if.input_port1), 32'h5);
        end
        set_ops(4'hA, 4'h9);
        edges(6);
        check("t3_port1_early", 32'(u_if.input_port1), 32'h5);
        edges(1);
        check("t3_port1", 32'(u_if.input_port1), 32'hA);
        check("t3_count", 32'(u_if.change_count), 32'h2);

        // 4: back to 5, then a 6 glitch that returns to 5
        set_ops(4'h5, 4'h9);
        hold(10);
        set_ops(4'h6, 4'h9);
        hold(2);
        set_ops(4'h5, 4'h9);
        hold(12);
        check("t4_port1", 32'(u_if.input_port1), 32'h5);
        check("t4_count", 32'(u_if.change_count), 32'h3);

        // 5: clear coincident with a commit loses; lone clear wins; clear at 0 is a no-op
        set_ops(4'h5, 4'h3);
        edges(6);
        u_if.clear_changed = 1'b1;
        edges(1);
        u_if.clear_changed = 1'b0;
        check("t5_set_wins", 32'(u_if.changed), 32'h1);
        check("t5_count", 32'(u_if.change_count), 32'h4);
        @(negedge clk);
        #1 u_if.clear_changed = 1'b1;
        edges(1);
        u_if.clear_changed = 1'b0;
        check("t5_cleared", 32'(u_if.changed), 32'h0);
        @(negedge clk);
        #1 u_if.clear_changed = 1'b1;
        edges(1);
        u_if.clear_changed = 1'b0;
        check("t5_clear_idle", 32'(u_if.changed), 32'h0);

        // 6: async reset in the middle of a window, then recommit without a pulse
        set_ops(4'h9, 4'h3);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_async_port1", 32'(u_if.input_port1), 32'h0);
        check("t6_async_port2", 32'(u_if.input_port2), 32'h0);
        check("t6_async_count", 32'(u_if.change_count), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        edges(6);
        check("t6_port1_early", 32'(u_if.input_port1), 32'h0);
        edges(1);
        check("t6_port1", 32'(u_if.input_port1), 32'h9);
        check("t6_valid", 32'(u_if.input_valid), 32'h1);
        check("t6_pulse", 32'(u_if.change_pulse), 32'h0);
        check("t6_count", 32'(u_if.change_count), 32'h0);

        // Both groups together: one pulse, count +2
        set_ops(4'h1, 4'h2);
        edges(7);
        check("both_pulse", 32'(u_if.change_pulse), 32'h1);
        check("both_count", 32'(u_if.change_count), 32'h2);

        // 256 further changes wrap the counter back to 2
        for (int i = 0; i < 128; i++) begin
            set_ops((i % 2 == 0) ? 4'h3 : 4'h1, (i % 2 == 0) ? 4'h4 : 4'h2);
            hold(8);
        end
        edges(8);
        check("wrap_count", 32'(u_if.change_count), 32'h2);

        // Random traffic with independent per-group hold times and sporadic clears
        h1 = 0;
        h2 = 0;
        v1 = u_if.op1;
        v2 = u_if.op2;
        for (int i = 0; i < 2000; i++) begin
            if (h1 == 0) begin
                v1 = val_t'($urandom_range(0, 15));
                h1 = $urandom_range(1, 9);
            end else h1--;
            if (h2 == 0) begin
                v2 = val_t'($urandom_range(0, 15));
                h2 = $urandom_range(1, 9);
            end else h2--;
            set_ops(v1, v2);
            u_if.clear_changed = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        #1 u_if.clear_changed = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
